// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader. Accepts a length-prefixed stream of 32-bit
// instruction words over a valid/ready handshake and writes them to
// consecutive instruction-memory word addresses. When the load completes it
// releases the processor core through cpu_run.
//
// Stream format: one length word N, then N data words. With the
// PROG_LOADER_CHECKSUM_EN macro defined, one more word follows. That word must
// equal the XOR of the length word and every data word.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (undefined by default).
//
// Ports
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   start        : single-cycle request to begin a load
//   in_valid     : stream word present
//   in_data      : stream word
//   in_ready     : loader accepts a word this cycle
//   mem_we       : instruction-memory write strobe (one cycle per word)
//   mem_addr     : write word address
//   mem_wdata    : write data
//   cpu_run      : high releases the core
//   busy         : load in progress
//   error        : load failed; the core is held
//   loaded_count : words written in the current or last load
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  error,
    output logic [15:0]           loaded_count
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_CHK  = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // The base address wraps into the address space, like every later address.
    localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
    // The length word is compared at its full 32-bit width.
    localparam logic [31:0]           MAX_LEN = 32'(MAX_WORDS);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Fold one stream word into the running checksum.
    function automatic logic [31:0] chk_fold(input logic [31:0] acc,
                                             input logic [31:0] word);
        return acc ^ word;
    endfunction

    logic [31:0]           xor_r;
`endif

    state_t                state_r;
    logic [31:0]           len_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  accept_s;
    logic                  last_s;

    // A word is consumed only when both sides agree in the same cycle.
    assign accept_s = in_valid && in_ready;
    // True when the word being accepted in LOAD is the N-th data word.
    assign last_s   = (({16'd0, loaded_count} + 32'd1) == len_r);

    // Loader FSM; every output is a register so reset clears it immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            len_r        <= 32'd0;
            addr_r       <= {ADDR_WIDTH{1'b0}};
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= {ADDR_WIDTH{1'b0}};
            mem_wdata    <= 32'd0;
            cpu_run      <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            loaded_count <= 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_r        <= 32'd0;
`endif
        end else begin
            // The write strobe is a one-cycle pulse after each data accept.
            mem_we <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r  <= ST_HDR;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (accept_s) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        xor_r <= in_data;
`endif
                        if (in_data > MAX_LEN) begin
                            state_r  <= ST_ERR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else if (in_data == 32'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_r  <= ST_CHK;
`else
                            // No write to retire, so the core is released now.
                            state_r  <= ST_RUN;
                            cpu_run  <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
`endif
                        end else begin
                            state_r      <= ST_LOAD;
                            len_r        <= in_data;
                            addr_r       <= BASE_A;
                            loaded_count <= 16'd0;
                        end
                    end else begin
                        state_r <= ST_HDR;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        mem_we       <= 1'b1;
                        mem_addr     <= addr_r;
                        mem_wdata    <= in_data;
                        addr_r       <= addr_r + ADDR_WIDTH'(1);
                        loaded_count <= loaded_count + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        xor_r        <= chk_fold(xor_r, in_data);
                        if (last_s) begin
                            state_r <= ST_CHK;
                        end else begin
                            state_r <= ST_LOAD;
                        end
`else
                        // The final write retires in the same cycle cpu_run
                        // rises; busy stays high for that write cycle.
                        if (last_s) begin
                            state_r  <= ST_RUN;
                            cpu_run  <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            state_r  <= ST_LOAD;
                        end
`endif
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept_s) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == xor_r) begin
                            state_r <= ST_RUN;
                            cpu_run <= 1'b1;
                        end else begin
                            state_r <= ST_ERR;
                            error   <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_CHK;
                    end
                end
`endif
                ST_RUN: begin
                    busy <= 1'b0;
                    if (start) begin
                        state_r      <= ST_HDR;
                        cpu_run      <= 1'b0;
                        error        <= 1'b0;
                        loaded_count <= 16'd0;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_ERR: begin
                    if (start) begin
                        state_r  <= ST_HDR;
                        error    <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state_r <= ST_ERR;
                    end
                end
                default: begin
                    // Unused encodings recover to a quiet idle.
                    state_r  <= ST_IDLE;
                    in_ready <= 1'b0;
                    cpu_run  <= 1'b0;
                    busy     <= 1'b0;
                    error    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        busy;
    logic        error;
    logic [15:0] loaded_count;

    prog_loader #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (0),
        .MAX_WORDS  (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .error        (error),
        .loaded_count (loaded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle vector: inputs for one edge, outputs expected right after it.
    typedef struct {
        logic        s;
        logic        v;
        logic [31:0] d;
        logic        rdy;
        logic        we;
        logic [9:0]  a;
        logic [31:0] wd;
        logic        run;
        logic        bsy;
        logic        err;
        logic [15:0] lc;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic s, input logic v, input logic [31:0] d,
                           input logic rdy, input logic we, input logic [9:0] a,
                           input logic [31:0] wd, input logic run, input logic bsy,
                           input logic err, input logic [15:0] lc);
        vec_t t;
        t.s = s; t.v = v; t.d = d; t.rdy = rdy; t.we = we; t.a = a; t.wd = wd;
        t.run = run; t.bsy = bsy; t.err = err; t.lc = lc;
        tbl.push_back(t);
    endtask

    // Write monitor: records each strobe with the cpu_run seen in that cycle.
    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic        wr_q[$];

    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wr_q.push_back(cpu_run);
        end
    end

    logic [31:0] stim_q[$];

    // Append the expected checksum word when the feature is built in.
    task automatic add_chk();
        logic [31:0] x;
        x = 32'd0;
        foreach (stim_q[k]) x = x ^ stim_q[k];
        if (CHK_EN) stim_q.push_back(x);
    endtask

    // Pulse start, then stream stim_q; gap=1 drops in_valid on alternate cycles.
    task automatic stream(input int gap);
        int  idx;
        int  cyc;
        bit  tog;
        idx = 0; cyc = 0; tog = 1'b0;
        wa_q.delete(); wd_q.delete(); wr_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (idx < stim_q.size() && cyc < 200) begin
            in_valid = (gap == 0) || tog;
            tog      = !tog;
            in_data  = in_valid ? stim_q[idx] : 32'hDEAD_BEEF;
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        in_data  = 32'd0;
        check("stream_complete", 64'(idx), 64'(stim_q.size()));
        repeat (3) @(negedge clk);
    endtask

    localparam logic [31:0] W0 = 32'h2008_0005;
    localparam logic [31:0] W1 = 32'h2009_FFFF;
    localparam logic [31:0] W2 = 32'h0109_5020;

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              64'({cpu_run, mem_we, busy, error, in_ready, loaded_count, mem_addr, mem_wdata}),
              64'd0);
        reset_n = 1'b1;

        // ---------------- cycle table ----------------
        //      s     v     data           rdy   we    a      wdata          run   bsy   err   lc
        add_vec(1'b1, 1'b0, 32'd0,         1'b1, 1'b0, 10'd0, 32'd0,         1'b0, 1'b1, 1'b0, 16'd0);
        add_vec(1'b0, 1'b1, 32'd3,         1'b1, 1'b0, 10'd0, 32'd0,         1'b0, 1'b1, 1'b0, 16'd0);
        add_vec(1'b0, 1'b1, W0,            1'b1, 1'b1, 10'd0, W0,            1'b0, 1'b1, 1'b0, 16'd1);
        add_vec(1'b0, 1'b1, W1,            1'b1, 1'b1, 10'd1, W1,            1'b0, 1'b1, 1'b0, 16'd2);
`ifdef PROG_LOADER_CHECKSUM_EN
        add_vec(1'b0, 1'b1, W2,            1'b1, 1'b1, 10'd2, W2,            1'b0, 1'b1, 1'b0, 16'd3);
        add_vec(1'b0, 1'b1, 32'h0108_AFD9, 1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b0, 1'b0, 16'd3);
`else
        add_vec(1'b0, 1'b1, W2,            1'b0, 1'b1, 10'd2, W2,            1'b1, 1'b1, 1'b0, 16'd3);
`endif
        // stream word while in RUN is ignored
        add_vec(1'b0, 1'b1, 32'h1234,      1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b0, 1'b0, 16'd3);
        // restart from RUN, zero-length program
        add_vec(1'b1, 1'b0, 32'd0,         1'b1, 1'b0, 10'd0, 32'd0,         1'b0, 1'b1, 1'b0, 16'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
        add_vec(1'b0, 1'b1, 32'd0,         1'b1, 1'b0, 10'd0, 32'd0,         1'b0, 1'b1, 1'b0, 16'd0);
        add_vec(1'b0, 1'b1, 32'd0,         1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b0, 1'b0, 16'd0);
`else
        add_vec(1'b0, 1'b1, 32'd0,         1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b0, 1'b0, 16'd0);
`endif
        // oversize header (MAX_WORDS=4), with a dropped-valid cycle first
        add_vec(1'b1, 1'b0, 32'd0,         1'b1, 1'b0, 10'd0, 32'd0,         1'b0, 1'b1, 1'b0, 16'd0);
        add_vec(1'b0, 1'b0, 32'd5,         1'b1, 1'b0, 10'd0, 32'd0,         1'b0, 1'b1, 1'b0, 16'd0);
        add_vec(1'b0, 1'b1, 32'd5,         1'b0, 1'b0, 10'd0, 32'd0,         1'b0, 1'b0, 1'b1, 16'd0);
        add_vec(1'b0, 1'b1, 32'd2,         1'b0, 1'b0, 10'd0, 32'd0,         1'b0, 1'b0, 1'b1, 16'd0);
        // restart from ERR; length with high bit set must not truncate to 2
        add_vec(1'b1, 1'b0, 32'd0,         1'b1, 1'b0, 10'd0, 32'd0,         1'b0, 1'b1, 1'b0, 16'd0);
        add_vec(1'b0, 1'b1, 32'h8000_0002, 1'b0, 1'b0, 10'd0, 32'd0,         1'b0, 1'b0, 1'b1, 16'd0);
        // recovery with a maximum-length load; start mid-load is ignored
        add_vec(1'b1, 1'b0, 32'd0,         1'b1, 1'b0, 10'd0, 32'd0,         1'b0, 1'b1, 1'b0, 16'd0);
        add_vec(1'b0, 1'b1, 32'd4,         1'b1, 1'b0, 10'd0, 32'd0,         1'b0, 1'b1, 1'b0, 16'd0);
        add_vec(1'b1, 1'b1, 32'h11,        1'b1, 1'b1, 10'd0, 32'h11,        1'b0, 1'b1, 1'b0, 16'd1);
        add_vec(1'b0, 1'b1, 32'h22,        1'b1, 1'b1, 10'd1, 32'h22,        1'b0, 1'b1, 1'b0, 16'd2);
        add_vec(1'b0, 1'b1, 32'h33,        1'b1, 1'b1, 10'd2, 32'h33,        1'b0, 1'b1, 1'b0, 16'd3);
`ifdef PROG_LOADER_CHECKSUM_EN
        add_vec(1'b0, 1'b1, 32'h44,        1'b1, 1'b1, 10'd3, 32'h44,        1'b0, 1'b1, 1'b0, 16'd4);
        add_vec(1'b0, 1'b1, 32'h40,        1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b0, 1'b0, 16'd4);
`else
        add_vec(1'b0, 1'b1, 32'h44,        1'b0, 1'b1, 10'd3, 32'h44,        1'b1, 1'b1, 1'b0, 16'd4);
`endif
        add_vec(1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 10'd0, 32'd0,         1'b1, 1'b0, 1'b0, 16'd4);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start    = tbl[i].s;
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ctrl", i),
                  64'({in_ready, mem_we, cpu_run, busy, error, loaded_count}),
                  64'({tbl[i].rdy, tbl[i].we, tbl[i].run, tbl[i].bsy, tbl[i].err, tbl[i].lc}));
            if (tbl[i].we) begin
                check($sformatf("vec%0d_write", i), 64'({mem_addr, mem_wdata}),
                      64'({tbl[i].a, tbl[i].wd}));
            end
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; in_data = 32'd0;

        // ---------------- backpressure: valid low on alternate cycles ----------------
        stim_q = '{32'd3, W0, W1, W2};
        add_chk();
        stream(1);
        check("bp_write_count", 64'(wa_q.size()), 64'd3);
        if (wa_q.size() == 3) begin
            check("bp_w0", 64'({wa_q[0], wd_q[0]}), 64'({10'd0, W0}));
            check("bp_w1", 64'({wa_q[1], wd_q[1]}), 64'({10'd1, W1}));
            check("bp_w2", 64'({wa_q[2], wd_q[2]}), 64'({10'd2, W2}));
            check("bp_run_at_last_write", 64'(wr_q[2]), 64'(!CHK_EN));
        end
        check("bp_final", 64'({cpu_run, busy, error, loaded_count}), 64'({1'b1, 1'b0, 1'b0, 16'd3}));

        // ---------------- reset in the middle of a load ----------------
        wa_q.delete(); wd_q.delete(); wr_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 32'd3;
        @(negedge clk); in_data = W0;
        @(negedge clk); in_data = W1;
        @(posedge clk);
        #2;
        check("pre_reset_write", 64'({mem_we, mem_addr, mem_wdata, loaded_count}),
              64'({1'b1, 10'd1, W1, 16'd2}));
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({cpu_run, mem_we, busy, error, in_ready, loaded_count, mem_addr, mem_wdata}),
              64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        stim_q = '{32'd3, W0, W1, W2};
        add_chk();
        stream(0);
        check("reload_write_count", 64'(wa_q.size()), 64'd3);
        if (wa_q.size() == 3) begin
            check("reload_w0", 64'({wa_q[0], wd_q[0]}), 64'({10'd0, W0}));
            check("reload_w2", 64'({wa_q[2], wd_q[2]}), 64'({10'd2, W2}));
        end
        check("reload_final", 64'({cpu_run, error, loaded_count}), 64'({1'b1, 1'b0, 16'd3}));

        // ---------------- two-word program; checksum match and mismatch ----------------
        stim_q = '{32'd2, 32'hA, 32'h5};
`ifdef PROG_LOADER_CHECKSUM_EN
        stim_q.push_back(32'hD);
`endif
        stream(0);
        check("two_word_writes", 64'(wa_q.size()), 64'd2);
        check("two_word_run", 64'({cpu_run, error, busy}), 64'({1'b1, 1'b0, 1'b0}));
`ifdef PROG_LOADER_CHECKSUM_EN
        stim_q = '{32'd2, 32'hA, 32'h5, 32'hC};
        stream(0);
        check("chk_bad_writes", 64'(wa_q.size()), 64'd2);
        check("chk_bad_error", 64'({cpu_run, error, busy, in_ready}), 64'({1'b0, 1'b1, 1'b0, 1'b0}));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
